counter_monitor: RTL and testbench

- Passive checker for the lab0 up-counter: samples the counter's output bus together with its enable and reset inputs each clock.
- Computes the value the counter must hold next cycle, flags deviations, counts errors and wrap-arounds.
- Sits beside the counter in benches and in the FPGA top level as a self-check. It only observes and never drives the counter.

---
 rtl/counter_monitor_pkg.sv | 14 +
 rtl/counter_monitor_if.sv | 24 ++
 rtl/sat_counter.sv | 26 ++
 rtl/counter_monitor.sv | 123 ++++++++++++
 tb/tb_counter_monitor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/counter_monitor_pkg.sv
// Shared state encoding and default widths for the lab0 counter monitor.
package counter_monitor_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_ERR_W  = 8;
    localparam int DEF_WRAP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/counter_monitor_if.sv
// Observation bundle: the counter's reset/enable inputs and its output bus.
interface counter_monitor_if
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             dut_reset_in;
    logic             dut_enable_in;
    logic [WIDTH-1:0] count_in;

    modport master (
        output dut_reset_in,
        output dut_enable_in,
        output count_in
    );

    modport slave (
        input dut_reset_in,
        input dut_enable_in,
        input count_in
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // count events, holding at the maximum value
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/counter_monitor.sv
// Passive self-check for the lab0 up-counter: predicts the next count,
// flags deviations and counts errors and wrap-arounds.
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int WRAP_W      = DEF_WRAP_W,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    counter_monitor_if.slave  obs,
    output logic [WIDTH-1:0]  expected,
    output logic              mismatch,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              halted
);

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] expected_r;
    logic [WIDTH-1:0] exp_nxt_s;
    logic [WIDTH-1:0] next_exp_s;
    logic             mismatch_r;
    logic             mis_nxt_s;
    logic             err_flag_r;
    logic             halted_r;
    logic             err_inc_s;
    logic             wrap_inc_s;
    logic             wrap_cond_s;

    // reference model of the counter: value it must show after this edge
    always_comb begin
        next_exp_s = obs.count_in;
        if (obs.dut_reset_in) begin
            next_exp_s = {WIDTH{1'b0}};
        end else if (obs.dut_enable_in) begin
            next_exp_s = obs.count_in + WIDTH'(1);
        end else begin
            next_exp_s = obs.count_in;
        end
    end

    assign wrap_cond_s = !obs.dut_reset_in && obs.dut_enable_in &&
                         (obs.count_in == {WIDTH{1'b1}});

    // next-state and registered-output decode
    always_comb begin
        state_s    = state_r;
        exp_nxt_s  = expected_r;
        mis_nxt_s  = 1'b0;
        err_inc_s  = 1'b0;
        wrap_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                exp_nxt_s = next_exp_s;
                state_s   = ST_TRACK;
            end
            ST_TRACK: begin
                wrap_inc_s = wrap_cond_s;
                // an unknown count falls through to the mismatch branch
                if (obs.count_in == expected_r) begin
                    exp_nxt_s = next_exp_s;
                end else begin
                    mis_nxt_s = 1'b1;
                    err_inc_s = 1'b1;
                    if (STOP_ON_ERR) begin
                        state_s = ST_HALT;
                    end else begin
                        exp_nxt_s = next_exp_s;
                    end
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s   = ST_IDLE;
                exp_nxt_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            expected_r <= {WIDTH{1'b0}};
            mismatch_r <= 1'b0;
            err_flag_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            expected_r <= exp_nxt_s;
            mismatch_r <= mis_nxt_s;
            err_flag_r <= err_flag_r | err_inc_s;
            halted_r   <= (state_s == ST_HALT);
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc_s),
        .cnt   (err_count)
    );

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc_s),
        .cnt   (wrap_count)
    );

    assign expected = expected_r;
    assign mismatch = mismatch_r;
    assign err_flag = err_flag_r;
    assign halted   = halted_r;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: a resync instance (2-bit counters)
// and a stop-on-error instance watch the same stimulated counter.
module tb_counter_monitor;

    logic clk = 1'b0;
    logic mon_rst;
    logic [3:0] cnt_v;

    always #5 clk = ~clk;

    counter_monitor_if #(.WIDTH(4)) obs_if ();

    logic [3:0] a_exp, b_exp;
    logic       a_mis, b_mis, a_flag, b_flag, a_halt, b_halt;
    logic [1:0] a_err, a_wrap;
    logic [7:0] b_err, b_wrap;

    counter_monitor #(.WIDTH(4), .ERR_W(2), .WRAP_W(2), .STOP_ON_ERR(1'b0)) dut_a (
        .clk        (clk),
        .reset      (mon_rst),
        .obs        (obs_if.slave),
        .expected   (a_exp),
        .mismatch   (a_mis),
        .err_flag   (a_flag),
        .err_count  (a_err),
        .wrap_count (a_wrap),
        .halted     (a_halt)
    );

    counter_monitor #(.WIDTH(4), .ERR_W(8), .WRAP_W(8), .STOP_ON_ERR(1'b1)) dut_b (
        .clk        (clk),
        .reset      (mon_rst),
        .obs        (obs_if.slave),
        .expected   (b_exp),
        .mismatch   (b_mis),
        .err_flag   (b_flag),
        .err_count  (b_err),
        .wrap_count (b_wrap),
        .halted     (b_halt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // behavioural model: per-instance predicted outputs
    int m_exp[2], m_err[2], m_wrap[2];
    bit m_mis[2], m_flag[2], m_halt[2], m_started[2];
    int err_max[2]  = '{3, 255};
    int wrap_max[2] = '{3, 255};
    bit stop[2]     = '{1'b0, 1'b1};
    bit model_valid = 1'b0;
    int cin, nxt;
    bit r_in, e_in;

    always @(posedge clk) begin
        r_in = obs_if.dut_reset_in;
        e_in = obs_if.dut_enable_in;
        cin  = int'(obs_if.count_in);
        nxt  = r_in ? 0 : (e_in ? (cin + 1) % 16 : cin);
        for (int i = 0; i < 2; i++) begin
            if (mon_rst) begin
                m_exp[i] = 0; m_err[i] = 0; m_wrap[i] = 0;
                m_mis[i] = 0; m_flag[i] = 0; m_halt[i] = 0; m_started[i] = 0;
            end else if (!m_started[i]) begin
                m_exp[i] = nxt; m_mis[i] = 0; m_started[i] = 1;
            end else if (m_halt[i]) begin
                m_mis[i] = 0;
            end else begin
                if (!r_in && e_in && cin == 15 && m_wrap[i] < wrap_max[i]) m_wrap[i]++;
                if (cin != m_exp[i]) begin
                    m_mis[i] = 1; m_flag[i] = 1;
                    if (m_err[i] < err_max[i]) m_err[i]++;
                    if (stop[i]) m_halt[i] = 1;
                    else m_exp[i] = nxt;
                end else begin
                    m_mis[i] = 0; m_exp[i] = nxt;
                end
            end
        end
        if (mon_rst) model_valid = 1'b1;
    end

    logic [31:0] o_exp[2], o_err[2], o_wrap[2], o_mis[2], o_flag[2], o_halt[2];
    assign o_exp[0]  = {28'd0, a_exp};   assign o_exp[1]  = {28'd0, b_exp};
    assign o_err[0]  = {30'd0, a_err};   assign o_err[1]  = {24'd0, b_err};
    assign o_wrap[0] = {30'd0, a_wrap};  assign o_wrap[1] = {24'd0, b_wrap};
    assign o_mis[0]  = {31'd0, a_mis};   assign o_mis[1]  = {31'd0, b_mis};
    assign o_flag[0] = {31'd0, a_flag};  assign o_flag[1] = {31'd0, b_flag};
    assign o_halt[0] = {31'd0, a_halt};  assign o_halt[1] = {31'd0, b_halt};

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d.expected", i),   o_exp[i],  m_exp[i]);
                chk($sformatf("dut%0d.mismatch", i),   o_mis[i],  32'(m_mis[i]));
                chk($sformatf("dut%0d.err_flag", i),   o_flag[i], 32'(m_flag[i]));
                chk($sformatf("dut%0d.err_count", i),  o_err[i],  m_err[i]);
                chk($sformatf("dut%0d.wrap_count", i), o_wrap[i], m_wrap[i]);
                chk($sformatf("dut%0d.halted", i),     o_halt[i], 32'(m_halt[i]));
            end
        end
    end

    // one clock of stimulus; cnt_v plays the real counter
    task automatic cyc(input logic mr, input logic r, input logic e);
        @(negedge clk);
        mon_rst              = mr;
        obs_if.dut_reset_in  = r;
        obs_if.dut_enable_in = e;
        obs_if.count_in      = cnt_v;
        @(posedge clk);
        if (r) cnt_v = 4'd0;
        else if (e) cnt_v = cnt_v + 4'd1;
        else cnt_v = cnt_v;
    endtask

    initial begin
        mon_rst = 1'b1;
        cnt_v = 4'd0;
        obs_if.dut_reset_in = 1'b0;
        obs_if.dut_enable_in = 1'b0;
        obs_if.count_in = 4'd0;

        cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
        #1;
        chk("rst.expected", {28'd0, a_exp}, 32'd0);
        chk("rst.mismatch", {31'd0, a_mis}, 32'd0);
        chk("rst.err_count", {30'd0, a_err}, 32'd0);
        chk("rst.wrap_count", {30'd0, a_wrap}, 32'd0);
        chk("rst.halted", {31'd0, b_halt}, 32'd0);

        // nominal: two counter-reset cycles then 20 counts
        cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("nom.err_count", {30'd0, a_err}, 32'd0);
        chk("nom.wrap_count_a", {30'd0, a_wrap}, 32'd1);
        chk("nom.wrap_count_b", {24'd0, b_wrap}, 32'd1);
        chk("nom.expected", {28'd0, a_exp}, 32'd4);

        // enable stall at 6
        cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        #1;
        chk("stall.expected", {28'd0, a_exp}, 32'd6);
        chk("stall.mismatch", {31'd0, a_mis}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("reen.expected", {28'd0, a_exp}, 32'd7);

        // injected error: 9 seen where 5 is expected
        cyc(1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("inj.pre_expected", {28'd0, a_exp}, 32'd5);
        cnt_v = 4'd9;
        cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("inj.a_mismatch", {31'd0, a_mis}, 32'd1);
        chk("inj.a_err_count", {30'd0, a_err}, 32'd1);
        chk("inj.a_expected", {28'd0, a_exp}, 32'd10);
        chk("inj.b_halted", {31'd0, b_halt}, 32'd1);
        chk("inj.b_expected", {28'd0, b_exp}, 32'd5);
        cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("inj.a_mismatch_pulse", {31'd0, a_mis}, 32'd0);
        chk("inj.a_resync", {28'd0, a_exp}, 32'd11);
        chk("inj.b_still_halted", {31'd0, b_halt}, 32'd1);
        cnt_v = 4'd3;
        cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("inj2.a_err_count", {30'd0, a_err}, 32'd2);
        chk("inj2.b_err_frozen", {24'd0, b_err}, 32'd1);
        chk("inj2.b_mismatch", {31'd0, b_mis}, 32'd0);

        // monitor reset clears everything, including HALT
        cyc(1'b1, 1'b1, 1'b0);
        #1;
        chk("clr.b_halted", {31'd0, b_halt}, 32'd0);
        chk("clr.b_err_count", {24'd0, b_err}, 32'd0);
        chk("clr.a_err_flag", {31'd0, a_flag}, 32'd0);

        // counter reset at 12 is not an error
        repeat (12) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        #1;
        chk("dutrst.expected", {28'd0, a_exp}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("dutrst.mismatch", {31'd0, a_mis}, 32'd0);
        chk("dutrst.next", {28'd0, a_exp}, 32'd1);

        // monitor reset at 12, then an uncompared first edge
        repeat (11) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        #1;
        chk("monrst.expected", {28'd0, a_exp}, 32'd0);
        cnt_v = 4'd7;
        cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("monrst.uncompared", {31'd0, a_mis}, 32'd0);
        chk("monrst.expected8", {28'd0, a_exp}, 32'd8);
        cyc(1'b0, 1'b0, 1'b1);

        // error counter saturation
        repeat (5) begin
            cnt_v = cnt_v + 4'd3;
            cyc(1'b0, 1'b0, 1'b1);
        end
        #1;
        chk("sat.err_count", {30'd0, a_err}, 32'd3);
        chk("sat.err_flag", {31'd0, a_flag}, 32'd1);

        // wrap counter saturation: five 15->0 transitions
        cyc(1'b1, 1'b1, 1'b0);
        repeat (80) cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("sat.wrap_a", {30'd0, a_wrap}, 32'd3);
        chk("sat.wrap_b", {24'd0, b_wrap}, 32'd5);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
